// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS multi-cycle control unit
package mips_pkg;

    // Primary opcodes (instr[31:26]) and R-type funct codes (instr[5:0])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;

    // ALU operation codes
    localparam logic [3:0] ALU_ADDIU = 4'b0000;
    localparam logic [3:0] ALU_SW    = 4'b0001;
    localparam logic [3:0] ALU_ADDU  = 4'b0010;

    // Operand B selects
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - maps control state and opcode to ALU operation and operand selects
module alu_op_decoder
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b
);

    // ALU-side encoding per state; execute states share one rule keyed on the opcode
    always_comb begin
        alu_ctrl  = ALU_ADDIU;
        alu_src_a = 1'b0;
        alu_src_b = SRC_B_RT;
        case (state)
            ST_FETCH: begin
                alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_ctrl  = ALU_SW;
            end
            ST_EXEC_R, ST_EXEC_I, ST_BRANCH: begin
                // addiu adds the immediate; addu and beq compare/add rs with rt
                alu_src_a = 1'b1;
                if (state == ST_EXEC_I && opcode == OP_ADDIU) begin
                    alu_src_b = SRC_B_IMM;
                    alu_ctrl  = ALU_ADDIU;
                end else begin
                    alu_src_b = SRC_B_RT;
                    alu_ctrl  = ALU_ADDU;
                end
            end
            default: begin
                alu_ctrl  = ALU_ADDIU;
                alu_src_a = 1'b0;
                alu_src_b = SRC_B_RT;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS control FSM driving datapath muxes and enables
module mips_mc_control
    import mips_pkg::*;
#(
    parameter logic RESET_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        target_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    // Register fields and the jump target are consumed by the datapath, not here
    assign unused_instr = ^instr[25:6];

    assign state   = state_q;
    assign illegal = illegal_q;

    alu_op_decoder u_alu_op_decoder (
        .state     (state_q),
        .opcode    (opcode),
        .alu_ctrl  (alu_ctrl),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b)
    );

    // Next-state selection; an unsupported decode parks the FSM in HALT and latches illegal
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_ADDIU:     state_d = ST_EXEC_I;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_RTYPE: begin
                        if (funct == FN_ADDU) begin
                            state_d = ST_EXEC_R;
                        end else begin
                            state_d   = ST_HALT;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WR: begin
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXEC_R: state_d = ST_R_WB;
            ST_EXEC_I: state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State and sticky illegal flag; reset restarts at FETCH and drops any pending access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= RESET_ILLEGAL;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes and datapath selects decoded from the current state
    always_comb begin
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_SRC_ALU;
        target_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_en    = mem_ready;
            end
            ST_DECODE: target_write = 1'b1;
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_I_WB: reg_write = 1'b1;
            ST_BRANCH: begin
                pc_src = PC_SRC_ALU_OUT;
                pc_en  = alu_zero;
            end
            ST_JUMP: begin
                pc_src = PC_SRC_JUMP;
                pc_en  = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - scoreboard bench for the multi-cycle control unit
module tb_mips_mc_control;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic [3:0]  alu_ctrl;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        iord, mem_read, mem_write, ir_write, pc_en;
    logic [1:0]  pc_src;
    logic        target_write, reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0]  state;

    mips_mc_control #(.RESET_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .target_write(target_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] word;
        logic        mr;
        logic        z;
    } step_t;

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    logic  exp_illegal = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [22:0] dut_word();
        return {state, alu_ctrl, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                pc_en, pc_src, target_write, reg_write, reg_dst, mem_to_reg, illegal};
    endfunction

    // Expected control word for one cycle, straight from the per-state output table
    function automatic logic [22:0] exp_word(input state_t st, input logic mr, input logic z, input logic ill);
        logic [3:0] ac; logic sa; logic [1:0] sb; logic io, rd, wr, irw, pe; logic [1:0] ps;
        logic tw, rw, rdst, m2r;
        ac = 4'b0000; sa = 0; sb = 2'b00; io = 0; rd = 0; wr = 0; irw = 0; pe = 0; ps = 2'b00;
        tw = 0; rw = 0; rdst = 0; m2r = 0;
        case (st)
            ST_FETCH:    begin rd = 1; sb = 2'b01; irw = mr; pe = mr; end
            ST_DECODE:   begin sb = 2'b11; tw = 1; end
            ST_MEM_ADDR: begin sa = 1; sb = 2'b10; ac = 4'b0001; end
            ST_MEM_RD:   begin rd = 1; io = 1; end
            ST_MEM_WB:   begin rw = 1; m2r = 1; end
            ST_MEM_WR:   begin wr = 1; io = 1; end
            ST_EXEC_R:   begin sa = 1; sb = 2'b00; ac = 4'b0010; end
            ST_R_WB:     begin rw = 1; rdst = 1; end
            ST_EXEC_I:   begin sa = 1; sb = 2'b10; ac = 4'b0000; end
            ST_I_WB:     begin rw = 1; end
            ST_BRANCH:   begin sa = 1; sb = 2'b00; ac = 4'b0010; ps = 2'b01; pe = z; end
            ST_JUMP:     begin ps = 2'b10; pe = 1; end
            default:     begin ac = 4'b0000; end
        endcase
        return {st, ac, sa, sb, io, rd, wr, irw, pe, ps, tw, rw, rdst, m2r, ill};
    endfunction

    task automatic push(input state_t st, input logic mr, input logic z);
        step_t s;
        s.word = exp_word(st, mr, z, exp_illegal);
        s.mr = mr;
        s.z = z;
        exp_q.push_back(s);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Pop each expected step, drive its inputs, compare mid-cycle, then advance one clock
    task automatic drain(input string tag);
        step_t s;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            mem_ready = s.mr;
            alu_zero = s.z;
            #2;
            check_val(tag, 32'(dut_word()), 32'(s.word));
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input int fetch_wait,
                             input int mem_wait, input logic z, input int exp_cycles);
        logic [5:0] op;
        op = ins[31:26];
        instr = ins;
        cyc = 0;
        for (int i = 0; i < fetch_wait; i++) push(ST_FETCH, 1'b0, rnd());
        push(ST_FETCH, 1'b1, rnd());
        push(ST_DECODE, rnd(), rnd());
        case (op)
            OP_LW: begin
                push(ST_MEM_ADDR, rnd(), rnd());
                for (int i = 0; i < mem_wait; i++) push(ST_MEM_RD, 1'b0, rnd());
                push(ST_MEM_RD, 1'b1, rnd());
                push(ST_MEM_WB, rnd(), rnd());
            end
            OP_SW: begin
                push(ST_MEM_ADDR, rnd(), rnd());
                for (int i = 0; i < mem_wait; i++) push(ST_MEM_WR, 1'b0, rnd());
                push(ST_MEM_WR, 1'b1, rnd());
            end
            OP_ADDIU: begin push(ST_EXEC_I, rnd(), rnd()); push(ST_I_WB, rnd(), rnd()); end
            OP_RTYPE: begin push(ST_EXEC_R, rnd(), rnd()); push(ST_R_WB, rnd(), rnd()); end
            OP_BEQ:   push(ST_BRANCH, rnd(), z);
            default:  push(ST_JUMP, rnd(), rnd());
        endcase
        drain(tag);
        check_val({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check_val({tag, "_in_fetch"}, 32'(state), 32'(ST_FETCH));
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] ins, input int halt_cycles);
        instr = ins;
        push(ST_FETCH, 1'b1, rnd());
        push(ST_DECODE, rnd(), rnd());
        drain({tag, "_decode"});
        exp_illegal = 1'b1;
        for (int i = 0; i < halt_cycles; i++) push(ST_HALT, rnd(), rnd());
        drain({tag, "_halt"});
        check_val({tag, "_sticky"}, 32'(illegal), 32'd1);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_illegal = 1'b0;
        check_val({tag, "_rst_state"}, 32'(state), 32'(ST_FETCH));
        check_val({tag, "_rst_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_state", 32'(state), 32'(ST_FETCH));
        check_val("reset_illegal", 32'(illegal), 32'd0);
        check_val("reset_fetch_idle", 32'({mem_read, iord, ir_write, pc_en}), 32'b1000);
        rst_n = 1'b1;

        run_instr("addu",     32'h00221821, 0, 0, 1'b0, 4);
        run_instr("addiu",    32'h24010005, 0, 0, 1'b0, 4);
        run_instr("lw_zw",    32'h8C220000, 0, 0, 1'b0, 5);
        run_instr("lw_wait3", 32'h8C220000, 0, 3, 1'b0, 8);
        run_instr("sw_zw",    32'hAC220004, 0, 0, 1'b0, 4);
        run_instr("sw_waits", 32'hAC220004, 2, 1, 1'b0, 7);
        run_instr("beq_tk",   32'h10220004, 0, 0, 1'b1, 3);
        run_instr("beq_nt",   32'h10220004, 0, 0, 1'b0, 3);
        run_instr("j",        32'h08000010, 0, 0, 1'b0, 3);

        // Reset while MEM_RD waits on memory: the pending read must be dropped
        instr = 32'h8C220000;
        push(ST_FETCH, 1'b1, 1'b0);
        push(ST_DECODE, 1'b0, 1'b0);
        push(ST_MEM_ADDR, 1'b0, 1'b0);
        drain("rst_mid_pre");
        mem_ready = 1'b0;
        #2;
        check_val("rst_mid_in_memrd", 32'(state), 32'(ST_MEM_RD));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("rst_mid_state", 32'(state), 32'(ST_FETCH));
        check_val("rst_mid_strobes", 32'({mem_read, iord, reg_write, ir_write}), 32'b1000);

        run_instr("addu_after_rst", 32'h00221821, 1, 0, 1'b0, 5);

        run_illegal("op3f", 32'hFC000000, 100);
        run_illegal("bad_funct", 32'h00221820, 3);

        run_instr("j_final", 32'h08000010, 0, 0, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control unit for the MIPS datapath: the initiating side of the ALU interface. It sequences each instruction through fetch, decode, execute, memory and write-back states. Each cycle it drives the 4-bit ALU operation code and operand selects, and it consumes the ALU `zero` flag to resolve branches. It sits between the instruction register / memory handshake and the datapath muxes and register enables.

## Interface
Parameters:
- `RESET_ILLEGAL` (default `1'b0`): reset value of the `illegal` flag (kept for bench hooks; must stay 0 in synthesis).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr`  in  32  current instruction register contents; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `alu_zero`  in  1  ALU equality flag (arg1 == arg2).
- `alu_ctrl`  out  4  ALU operation: 0000 addiu, 0001 sw, 0010 addu.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm16, 11 = sign-extended imm16<<2.
- `iord`  out  1  memory address: 0 = PC, 1 = ALU-out register.
- `mem_read`, `mem_write`  out  1  memory strobes, held until `mem_ready`.
- `ir_write`  out  1  load the instruction register.
- `pc_en`  out  1  PC load enable.
- `pc_src`  out  2  00 = ALU result, 01 = ALU-out register, 10 = {PC[31:28], instr[25:0], 2'b00}.
- `target_write`  out  1  latch the ALU result into the branch-target register.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALU-out, 1 = memory data register.
- `illegal`  out  1  sticky: an unsupported opcode/funct was decoded.
- `state`  out  4  current state encoding, for debug.

## Operation
- Supported instructions: addiu (001001), lw (100011), sw (101011), beq (000100), j (000010), and R-type (000000) with funct addu (100001). Everything else is illegal.
- FETCH: `mem_read=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_ctrl=0000`. Wait here until `mem_ready`. In the `mem_ready` cycle, assert `ir_write`, `pc_en` and `pc_src=00` (PC += 4), then go to DECODE.
- DECODE: `alu_src_a=0`, `alu_src_b=11`, `alu_ctrl=0000`, `target_write=1`. Next state by opcode:
  - lw/sw → MEM_ADDR
  - addiu → EXEC_I
  - R-type addu → EXEC_R
  - beq → BRANCH
  - j → JUMP
  - else → HALT with `illegal` set
- MEM_ADDR: `alu_src_a=1`, `alu_src_b=10`, `alu_ctrl=0001`. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: `mem_read=1`, `iord=1`. Wait for `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=1`. Then FETCH.
- MEM_WR: `mem_write=1`, `iord=1`. Wait for `mem_ready`, then FETCH.
- EXEC_R: `alu_src_a=1`, `alu_src_b=00`, `alu_ctrl=0010`. Then R_WB.
- R_WB: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0`. Then FETCH.
- EXEC_I: `alu_src_a=1`, `alu_src_b=10`, `alu_ctrl=0000`. Then I_WB.
- I_WB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=0`. Then FETCH.
- BRANCH: `alu_src_a=1`, `alu_src_b=00`, `alu_ctrl=0010`, `pc_src=01`, `pc_en=alu_zero`. Then FETCH.
- JUMP: `pc_src=10`, `pc_en=1`. Then FETCH.
- HALT: terminal. All strobes 0. Left only by reset.
- Default in every state: every strobe/enable is 0; select outputs are 0 unless specified above.

## Timing
- State register updates on `clk`. All outputs decode combinationally from state; `ir_write`, `pc_en` (FETCH, BRANCH) additionally depend on `mem_ready`/`alu_zero`.
- Reset: when `rst_n=0` at an edge, state becomes FETCH and `illegal` becomes `RESET_ILLEGAL`. This applies mid-instruction and mid-handshake; a pending `mem_read`/`mem_write` is dropped. While in FETCH after reset, outputs are the FETCH values with `ir_write=pc_en=0` unless `mem_ready`.
- Cycle counts with zero-wait memory (`mem_ready` high the first cycle):
  - lw: 5
  - sw, addu, addiu: 4
  - beq, j: 3
- Each wait cycle adds exactly one cycle.
- `mem_ready` is ignored in every state except FETCH, MEM_RD and MEM_WR.
- `mem_read`/`mem_write` stay stable and asserted until the `mem_ready` cycle, and deassert the following cycle.
- `alu_zero` is sampled only in BRANCH.

## Structure
- Package `mips_pkg`:
  - opcode/funct constants
  - ALU ctrl constants (0000/0001/0010)
  - `alu_src_b` and `pc_src` encodings
  - `state_t` enum (13 states, 4-bit)
- Sub-module `alu_op_decoder`: combinational map from (state, opcode) to `alu_ctrl`, `alu_src_a`, `alu_src_b`. This keeps the ALU-side encoding in one place. The FSM proper lives in `mips_mc_control`.

## Test plan
- Reset mid-MEM_RD (`mem_ready=0`, `rst_n=0` one edge) → next cycle `state`=FETCH, `mem_read=1`, `iord=0`, `reg_write=0`.
- addu $3,$1,$2 (0x00221821), zero-wait → 4 cycles. R_WB has `reg_write=1`, `reg_dst=1`. EXEC_R has `alu_ctrl=0010`, `alu_src_b=00`.
- lw with `mem_ready` low 3 cycles in MEM_RD → 8 total cycles. `mem_read` stays high through the wait. MEM_WB has `mem_to_reg=1`.
- beq (0x10220004) with `alu_zero=1` → `pc_en=1`, `pc_src=01` in BRANCH. With `alu_zero=0` → `pc_en=0`. Both take 3 cycles.
- j 0x0000040 (0x08000010) → JUMP asserts `pc_en=1`, `pc_src=10`. Back in FETCH on cycle 4.
- Opcode 0x3F → HALT, `illegal=1`. Holds with all strobes 0 for 100 cycles. Cleared only by `rst_n=0`.
